// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//   Programmable VGA timing generator for the pixel clock domain. Produces
//   active-low hsync/vsync, data-enable, pixel coordinates and a pixel fetch
//   request that leads de by one cycle. Timing is held in an active register
//   set. A shadow set takes host writes. The shadow set is copied to the
//   active set only at a frame boundary, or when the timing starts, so a mode
//   change never tears a frame.
//
// Ports
//   pixel_clk, rst_n       clock, synchronous active-low reset
//   enable                 run timing; low forces idle outputs
//   cfg_we/cfg_sel         shadow write strobe; 0 = horizontal, 1 = vertical
//   cfg_act/fp/sync/bp     phase lengths for the selected axis (all nonzero)
//   cfg_pending            shadow written but not yet applied
//   cfg_err                one-cycle pulse after a rejected write
//   hsync, vsync           active-low sync
//   de, x, y               active video and its coordinates
//   pix_req                de of the following cycle
//   line_start/frame_start first cycle of a line / frame
module vga_timing_ctrl #(
    parameter int HOR_ACT   = 640,
    parameter int HOR_FP    = 16,
    parameter int HOR_SYNC  = 96,
    parameter int HOR_BP    = 48,
    parameter int VERT_ACT  = 480,
    parameter int VERT_FP   = 11,
    parameter int VERT_SYNC = 2,
    parameter int VERT_BP   = 31
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cfg_we,
    input  logic        cfg_sel,
    input  logic [10:0] cfg_act,
    input  logic [7:0]  cfg_fp,
    input  logic [7:0]  cfg_sync,
    input  logic [7:0]  cfg_bp,
    output logic        cfg_pending,
    output logic        cfg_err,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        pix_req,
    output logic        line_start,
    output logic        frame_start
);

    // Phase order is SYNC -> BP -> ACT -> FP -> SYNC, so the next phase is
    // the 2-bit increment of the current one.
    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_BP   = 2'd1;
    localparam logic [1:0] ST_ACT  = 2'd2;
    localparam logic [1:0] ST_FP   = 2'd3;

    typedef struct packed {
        logic [10:0] act;
        logic [7:0]  fp;
        logic [7:0]  sync;
        logic [7:0]  bp;
    } axis_cfg_t;

    localparam axis_cfg_t H_DEF = '{act: 11'(HOR_ACT), fp: 8'(HOR_FP),
                                    sync: 8'(HOR_SYNC), bp: 8'(HOR_BP)};
    localparam axis_cfg_t V_DEF = '{act: 11'(VERT_ACT), fp: 8'(VERT_FP),
                                    sync: 8'(VERT_SYNC), bp: 8'(VERT_BP)};

    function automatic logic [10:0] phase_len(input logic [1:0] st, input axis_cfg_t c);
        case (st)
            ST_SYNC: phase_len = {3'd0, c.sync};
            ST_BP:   phase_len = {3'd0, c.bp};
            ST_ACT:  phase_len = c.act;
            default: phase_len = {3'd0, c.fp};
        endcase
    endfunction

    axis_cfg_t   h_cfg, v_cfg, sh_h, sh_v, eh, ev;
    logic        run;
    logic [1:0]  h_st, v_st, h_nx, v_nx, n_h_st, n_v_st, la_h_st, la_v_st;
    logic [10:0] h_cnt, v_cnt, n_h_cnt, n_v_cnt;
    logic        wr_ok, eol, eof, apply, n_de, n_pix_req;

    always_comb begin
        wr_ok = cfg_we & (cfg_act != '0) & (cfg_fp != '0) & (cfg_sync != '0) & (cfg_bp != '0);
        eol   = run & (h_st == ST_FP) & (h_cnt == '0);
        eof   = eol & (v_st == ST_FP) & (v_cnt == '0);
        // Shadow goes live on the frame boundary or on the first frame after
        // an enable rise; the phase loads below must already see it.
        apply = enable & cfg_pending & (~run | eof);
        eh    = apply ? sh_h : h_cfg;
        ev    = apply ? sh_v : v_cfg;
        h_nx  = h_st + 2'd1;
        v_nx  = v_st + 2'd1;

        n_h_st  = ST_SYNC;
        n_h_cnt = '0;
        n_v_st  = ST_SYNC;
        n_v_cnt = '0;
        if (enable && !run) begin
            n_h_cnt = {3'd0, eh.sync} - 11'd1;
            n_v_cnt = {3'd0, ev.sync} - 11'd1;
        end else if (enable) begin
            if (h_cnt == '0) begin
                n_h_st  = h_nx;
                n_h_cnt = phase_len(h_nx, eh) - 11'd1;
            end else begin
                n_h_st  = h_st;
                n_h_cnt = h_cnt - 11'd1;
            end
            n_v_st  = v_st;
            n_v_cnt = v_cnt;
            if (eol) begin
                if (v_cnt == '0) begin
                    n_v_st  = v_nx;
                    n_v_cnt = phase_len(v_nx, ev) - 11'd1;
                end else begin
                    n_v_cnt = v_cnt - 11'd1;
                end
            end
        end

        // One more step of lookahead from the next position gives de of the
        // cycle after, so pix_req stays registered yet leads de by one cycle.
        la_h_st = (n_h_cnt == '0) ? n_h_st + 2'd1 : n_h_st;
        la_v_st = ((n_h_st == ST_FP) && (n_h_cnt == '0) && (n_v_cnt == '0)) ? n_v_st + 2'd1 : n_v_st;

        n_de      = enable & (n_h_st == ST_ACT) & (n_v_st == ST_ACT);
        n_pix_req = enable & (la_h_st == ST_ACT) & (la_v_st == ST_ACT);
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            h_cfg       <= H_DEF;
            v_cfg       <= V_DEF;
            sh_h        <= H_DEF;
            sh_v        <= V_DEF;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
            run         <= 1'b0;
            h_st        <= ST_SYNC;
            v_st        <= ST_SYNC;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            pix_req     <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            run     <= enable;
            h_st    <= n_h_st;
            v_st    <= n_v_st;
            h_cnt   <= n_h_cnt;
            v_cnt   <= n_v_cnt;
            cfg_err <= cfg_we & ~wr_ok;

            // The active set takes the old shadow. A write landing on the same
            // edge only updates the shadow and stays pending.
            if (apply) begin
                h_cfg <= sh_h;
                v_cfg <= sh_v;
            end
            if (wr_ok) begin
                if (cfg_sel) sh_v <= '{act: cfg_act, fp: cfg_fp, sync: cfg_sync, bp: cfg_bp};
                else         sh_h <= '{act: cfg_act, fp: cfg_fp, sync: cfg_sync, bp: cfg_bp};
            end
            if (wr_ok)      cfg_pending <= 1'b1;
            else if (apply) cfg_pending <= 1'b0;

            hsync       <= ~(enable & (n_h_st == ST_SYNC));
            vsync       <= ~(enable & (n_v_st == ST_SYNC));
            de          <= n_de;
            pix_req     <= n_pix_req;
            line_start  <= enable & (~run | eol);
            frame_start <= enable & (~run | eof);

            // Counters run down, so the coordinate is act-1 minus the count.
            if (!enable) begin
                x <= '0;
                y <= '0;
            end else if (n_de) begin
                x <= eh.act - 11'd1 - n_h_cnt;
                y <= ev.act - 11'd1 - n_v_cnt;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl: a position-based reference model pushes the
// expected output vector for every clock; each scenario task pops and
// compares it and adds scenario-specific measurements.
module tb_vga_timing_ctrl;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        de;
        logic        pix_req;
        logic        line_start;
        logic        frame_start;
        logic        cfg_pending;
        logic        cfg_err;
        logic [10:0] x;
        logic [10:0] y;
    } obs_t;

    logic        pixel_clk = 1'b0;
    logic        rst_n     = 1'b0;
    logic        enable    = 1'b0;
    logic        cfg_we    = 1'b0;
    logic        cfg_sel   = 1'b0;
    logic [10:0] cfg_act   = '0;
    logic [7:0]  cfg_fp    = '0;
    logic [7:0]  cfg_sync  = '0;
    logic [7:0]  cfg_bp    = '0;
    logic        cfg_pending, cfg_err, hsync, vsync, de, pix_req, line_start, frame_start;
    logic [10:0] x, y;

    obs_t got;
    assign got = {hsync, vsync, de, pix_req, line_start, frame_start, cfg_pending, cfg_err, x, y};

    obs_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: index 0 = horizontal, 1 = vertical.
    int m_act[2], m_fp[2], m_sync[2], m_bp[2];
    int s_act[2], s_fp[2], s_sync[2], s_bp[2];
    bit m_pend = 0;
    bit m_run  = 0;
    int m_pos  = 0;
    int m_x    = 0;
    int m_y    = 0;

    always #5 pixel_clk = ~pixel_clk;

    vga_timing_ctrl dut (
        .pixel_clk   (pixel_clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_act     (cfg_act),
        .cfg_fp      (cfg_fp),
        .cfg_sync    (cfg_sync),
        .cfg_bp      (cfg_bp),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .pix_req     (pix_req),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    function automatic int tot(input int a);
        return m_sync[a] + m_bp[a] + m_act[a] + m_fp[a];
    endfunction

    function automatic bit act_at(input int p);
        int hp, ln;
        hp = p % tot(0);
        ln = p / tot(0);
        return (hp >= m_sync[0] + m_bp[0]) && (hp < m_sync[0] + m_bp[0] + m_act[0]) &&
               (ln >= m_sync[1] + m_bp[1]) && (ln < m_sync[1] + m_bp[1] + m_act[1]);
    endfunction

    task automatic load_defaults();
        m_act[0] = 640; m_fp[0] = 16; m_sync[0] = 96; m_bp[0] = 48;
        m_act[1] = 480; m_fp[1] = 11; m_sync[1] = 2;  m_bp[1] = 31;
        for (int i = 0; i < 2; i++) begin
            s_act[i] = m_act[i]; s_fp[i] = m_fp[i]; s_sync[i] = m_sync[i]; s_bp[i] = m_bp[i];
        end
    endtask

    task automatic apply_shadow();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = s_act[i]; m_fp[i] = s_fp[i]; m_sync[i] = s_sync[i]; m_bp[i] = s_bp[i];
        end
        m_pend = 0;
    endtask

    // Predict the outputs that follow the next rising edge from the inputs
    // currently driven, and queue them.
    task automatic model_step();
        obs_t e;
        bit   bad, wr;
        int   flen, hp, ln, i;
        bad = cfg_we && (cfg_act == 0 || cfg_fp == 0 || cfg_sync == 0 || cfg_bp == 0);
        wr  = cfg_we && !bad;
        e   = '0;
        if (!rst_n) begin
            load_defaults();
            m_pend = 0; m_run = 0; m_pos = 0; m_x = 0; m_y = 0;
            e.hsync = 1'b1;
            e.vsync = 1'b1;
        end else begin
            if (!enable) begin
                m_run = 0; m_pos = 0; m_x = 0; m_y = 0;
            end else begin
                flen = tot(0) * tot(1);
                if (!m_run || m_pos == flen - 1) begin
                    if (m_pend) apply_shadow();
                    m_pos = 0;
                    m_run = 1;
                end else begin
                    m_pos++;
                end
            end
            if (wr) begin
                i = cfg_sel ? 1 : 0;
                s_act[i] = int'(cfg_act); s_fp[i] = int'(cfg_fp);
                s_sync[i] = int'(cfg_sync); s_bp[i] = int'(cfg_bp);
                m_pend = 1;
            end
            e.cfg_pending = m_pend;
            e.cfg_err     = bad;
            if (!m_run) begin
                e.hsync = 1'b1;
                e.vsync = 1'b1;
            end else begin
                hp = m_pos % tot(0);
                ln = m_pos / tot(0);
                e.hsync       = (hp >= m_sync[0]);
                e.vsync       = (ln >= m_sync[1]);
                e.line_start  = (hp == 0);
                e.frame_start = (m_pos == 0);
                e.de          = act_at(m_pos);
                if (e.de) begin
                    m_x = hp - m_sync[0] - m_bp[0];
                    m_y = ln - m_sync[1] - m_bp[1];
                end
                e.pix_req = (m_pos + 1 < tot(0) * tot(1)) && act_at(m_pos + 1);
            end
            e.x = 11'(m_x);
            e.y = 11'(m_y);
        end
        sbq.push_back(e);
    endtask

    task automatic cycle(output obs_t e);
        model_step();
        @(posedge pixel_clk);
        #1;
        e = sbq.pop_front();
    endtask

    task automatic drive_cfg(input bit sel, input int act, input int fp, input int sync, input int bp);
        cfg_we = 1'b1; cfg_sel = sel;
        cfg_act = 11'(act); cfg_fp = 8'(fp); cfg_sync = 8'(sync); cfg_bp = 8'(bp);
    endtask

    task automatic test_reset();
        obs_t e;
        rst_n = 1'b0; enable = 1'b1;
        repeat (3) begin
            cycle(e); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL reset: got %h want %h", got, e); end
        end
        enable = 1'b0; rst_n = 1'b1;
        repeat (2) begin
            cycle(e); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL idle: got %h want %h", got, e); end
        end
    endtask

    task automatic test_default_timing();
        obs_t e;
        int hs_low = 0, vs_low = 0, ls = 0, de_cnt = 0, de_first = -1;
        bit ls800 = 0;
        enable = 1'b1;
        for (int c = 0; c < 27200; c++) begin
            cycle(e); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL default c%0d: got %h want %h", c, got, e); end
            if (c < 800 && !hsync) hs_low++;
            if (!vsync) vs_low++;
            if (line_start) ls++;
            if (c == 800) ls800 = line_start;
            if (c >= 26400 && de) begin
                de_cnt++;
                if (de_first < 0) de_first = c - 26400;
            end
        end
        vectors++;
        if (hs_low != 96)   begin miscompares++; $display("FAIL hsync_width: got %0d want 96", hs_low); end
        vectors++;
        if (vs_low != 1600) begin miscompares++; $display("FAIL vsync_width: got %0d want 1600", vs_low); end
        vectors++;
        if (ls != 34)       begin miscompares++; $display("FAIL line_count: got %0d want 34", ls); end
        vectors++;
        if (!ls800)         begin miscompares++; $display("FAIL htotal: got no line_start want one at cycle 800"); end
        vectors++;
        if (de_cnt != 640)  begin miscompares++; $display("FAIL de_width: got %0d want 640", de_cnt); end
        vectors++;
        if (de_first != 144) begin miscompares++; $display("FAIL de_offset: got %0d want 144", de_first); end
    endtask

    task automatic test_enable_drop();
        obs_t e;
        bit found = 0, seen_de = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            cycle(e); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL drop_run: got %h want %h", got, e); end
            if (de && x == 11'd300) found = 1;
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL x300_timeout: got no x=300 want x=300 within 2000"); end
        enable = 1'b0;
        cycle(e); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL drop_idle: got %h want %h", got, e); end
        vectors++;
        if (hsync !== 1'b1 || vsync !== 1'b1 || de !== 1'b0)
            begin miscompares++; $display("FAIL drop_outputs: got hs=%b vs=%b de=%b want 1 1 0", hsync, vsync, de); end
        // Load a small mode while idle; it must be picked up by the enable rise.
        drive_cfg(0, 6, 2, 1, 2);
        cycle(e); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL idle_wr_h: got %h want %h", got, e); end
        drive_cfg(1, 3, 1, 2, 1);
        cycle(e); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL idle_wr_v: got %h want %h", got, e); end
        cfg_we = 1'b0;
        vectors++;
        if (cfg_pending !== 1'b1) begin miscompares++; $display("FAIL idle_pending: got %b want 1", cfg_pending); end
        enable = 1'b1;
        cycle(e); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL reen: got %h want %h", got, e); end
        vectors++;
        if (frame_start !== 1'b1 || line_start !== 1'b1 || hsync !== 1'b0 || vsync !== 1'b0)
            begin miscompares++; $display("FAIL reen_start: got fs=%b ls=%b hs=%b vs=%b want 1 1 0 0", frame_start, line_start, hsync, vsync); end
        for (int c = 0; c < 153; c++) begin
            cycle(e); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL reen_run c%0d: got %h want %h", c, got, e); end
            if (de && !seen_de) begin
                seen_de = 1; vectors++;
                if (y !== 11'd0 || x !== 11'd0) begin miscompares++; $display("FAIL reen_first: got x=%0d y=%0d want 0 0", x, y); end
            end
        end
    endtask

    task automatic test_cfg_midframe();
        obs_t e;
        bit   hit = 0, prev_req = 0;
        int   len = -1, maxx = 0, maxy = 0;
        for (int c = 0; c < 200 && m_pos != 20; c++) begin
            cycle(e); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL mid_wait: got %h want %h", got, e); end
        end
        drive_cfg(0, 4, 1, 1, 1);
        cycle(e); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL mid_wr_h: got %h want %h", got, e); end
        drive_cfg(1, 2, 1, 1, 1);
        cycle(e); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL mid_wr_v: got %h want %h", got, e); end
        cfg_we = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            cycle(e); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL mid_pend: got %h want %h", got, e); end
            if (frame_start) hit = 1;
            else if (cfg_pending !== 1'b1) begin
                vectors++; miscompares++; $display("FAIL mid_pending_early: got %b want 1", cfg_pending);
            end
        end
        vectors++;
        if (!hit || cfg_pending !== 1'b0) begin miscompares++; $display("FAIL mid_apply: got fs=%b pend=%b want 1 0", hit, cfg_pending); end
        prev_req = pix_req;
        for (int c = 1; c < 200 && len < 0; c++) begin
            cycle(e); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL small_run: got %h want %h", got, e); end
            if (frame_start) len = c;
            else begin
                if (de && x > maxx) maxx = x;
                if (de && y > maxy) maxy = y;
                vectors++;
                if (de !== prev_req) begin miscompares++; $display("FAIL pix_lead c%0d: got de=%b want prior pix_req %b", c, de, prev_req); end
            end
            prev_req = pix_req;
        end
        vectors++;
        if (len != 35) begin miscompares++; $display("FAIL small_frame: got %0d want 35", len); end
        vectors++;
        if (maxx != 3 || maxy != 1) begin miscompares++; $display("FAIL small_xy: got x=%0d y=%0d want 3 1", maxx, maxy); end
    endtask

    task automatic test_cfg_err();
        obs_t e;
        drive_cfg(0, 4, 1, 0, 1);
        cycle(e); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL err_sb: got %h want %h", got, e); end
        vectors++;
        if (cfg_err !== 1'b1 || cfg_pending !== 1'b0)
            begin miscompares++; $display("FAIL err_pulse: got err=%b pend=%b want 1 0", cfg_err, cfg_pending); end
        cfg_we = 1'b0;
        cycle(e); vectors++;
        if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL err_width: got %b want 0", cfg_err); end
        repeat (70) begin
            cycle(e); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL err_run: got %h want %h", got, e); end
        end
    endtask

    task automatic test_boundary_write();
        obs_t e;
        int len1 = -1, len2 = -1;
        for (int c = 0; c < 100 && m_pos != 34; c++) begin
            cycle(e); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL bnd_wait: got %h want %h", got, e); end
        end
        drive_cfg(0, 6, 2, 1, 2);
        cycle(e); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL bnd_wr: got %h want %h", got, e); end
        cfg_we = 1'b0;
        vectors++;
        if (frame_start !== 1'b1 || cfg_pending !== 1'b1)
            begin miscompares++; $display("FAIL bnd_edge: got fs=%b pend=%b want 1 1", frame_start, cfg_pending); end
        for (int c = 1; c < 200 && len1 < 0; c++) begin
            cycle(e); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL bnd_f1: got %h want %h", got, e); end
            if (frame_start) len1 = c;
            else if (cfg_pending !== 1'b1) begin
                vectors++; miscompares++; $display("FAIL bnd_pending: got %b want 1", cfg_pending);
            end
        end
        vectors++;
        if (len1 != 35) begin miscompares++; $display("FAIL bnd_len1: got %0d want 35", len1); end
        for (int c = 1; c < 200 && len2 < 0; c++) begin
            cycle(e); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL bnd_f2: got %h want %h", got, e); end
            if (frame_start) len2 = c;
        end
        vectors++;
        if (len2 != 55) begin miscompares++; $display("FAIL bnd_len2: got %0d want 55", len2); end
    endtask

    task automatic test_reset_midframe();
        obs_t e;
        int hs_low = 0;
        bit ls800 = 0, ls1600 = 0;
        repeat (10) begin
            cycle(e); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL rst_pre: got %h want %h", got, e); end
        end
        drive_cfg(1, 2, 2, 1, 1);
        cycle(e); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL rst_wr: got %h want %h", got, e); end
        cfg_we = 1'b0;
        cycle(e); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL rst_mid: got %h want %h", got, e); end
        rst_n = 1'b0;
        cycle(e); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL rst_hit: got %h want %h", got, e); end
        vectors++;
        if (hsync !== 1'b1 || vsync !== 1'b1 || de !== 1'b0 || cfg_pending !== 1'b0 || x !== 11'd0)
            begin miscompares++; $display("FAIL rst_values: got hs=%b vs=%b de=%b pend=%b x=%0d want 1 1 0 0 0", hsync, vsync, de, cfg_pending, x); end
        rst_n = 1'b1;
        for (int c = 0; c < 1700; c++) begin
            cycle(e); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL rst_run c%0d: got %h want %h", c, got, e); end
            if (c < 800 && !hsync) hs_low++;
            if (c == 800) ls800 = line_start;
            if (c == 1600) ls1600 = line_start;
        end
        vectors++;
        if (!ls800 || !ls1600 || hs_low != 96)
            begin miscompares++; $display("FAIL rst_timing: got ls800=%b ls1600=%b hs_low=%0d want 1 1 96", ls800, ls1600, hs_low); end
    endtask

    initial begin
        load_defaults();
        test_reset();
        test_default_timing();
        test_enable_drop();
        test_cfg_midframe();
        test_cfg_err();
        test_boundary_write();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish before 5ms");
        $fatal(1);
    end

endmodule
